// File: rtl/vga_bram_fetch_pkg.sv
// Shared widths, default resolution and swap FSM encoding for vga_bram_fetch.
// The vga_params defines live at the top of this file so every later file sees them.
`ifndef VGA_PARAMS_V
`define VGA_PARAMS_V
`define D_WIDTH 8
`define P_WIDTH 10
`define VGA_H_RES 640
`define VGA_V_RES 480
`define VGA_FRAME_WORDS (640*480)
`define VGA_FRAME_WORDS_DBL (320*240)
`endif

package vga_bram_fetch_pkg;
   localparam int D_WIDTH = `D_WIDTH;
   localparam int P_WIDTH = `P_WIDTH;

   typedef enum logic {
      SWAP_IDLE    = 1'b0,
      SWAP_PENDING = 1'b1
   } swap_state_e;
endpackage

// File: rtl/vga_bram_fetch_if.sv
// Block-RAM read port between vga_bram_fetch (master) and the frame buffer (slave).
interface vga_bram_fetch_if
   import vga_bram_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 20
);
   logic [ADDR_WIDTH-1:0] bram_addr;
   logic                  bram_en;
   logic [3*D_WIDTH-1:0]  bram_dout;

   modport master (output bram_addr, output bram_en, input bram_dout);
   modport slave  (input bram_addr, input bram_en, output bram_dout);
endinterface

// File: rtl/vga_delay_line.sv
// Shift register of DEPTH stages, WIDTH bits each, with a per-bit reset value.
module vga_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [DEPTH-1:0][WIDTH-1:0] stage_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= {DEPTH{RST_VAL}};
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_bram_fetch.sv
// Double-buffered BRAM pixel fetch with tear-free page swap at end of frame.
// Optional VGA_PIXEL_DOUBLE_EN: quarter-size buffer, each word shown as a 2x2 block.
module vga_bram_fetch
   import vga_bram_fetch_pkg::*;
#(
   parameter int H_RES      = `VGA_H_RES,
   parameter int V_RES      = `VGA_V_RES,
   parameter int ADDR_WIDTH = 20,
   parameter int BRAM_LAT   = 1
) (
   input  logic               VGA_CLK,
   input  logic               RESET,
   input  logic [P_WIDTH-1:0] X,
   input  logic [P_WIDTH-1:0] Y,
   input  logic               valid,
   input  logic               HS_in,
   input  logic               VS_in,
   vga_bram_fetch_if.master   bram,
   input  logic               swap_req,
   output logic               swap_ack,
   output logic               page,
   output logic [D_WIDTH-1:0] Red,
   output logic [D_WIDTH-1:0] Green,
   output logic [D_WIDTH-1:0] Blue,
   output logic               valid_out,
   output logic               HS_out,
   output logic               VS_out
);
`ifdef VGA_PIXEL_DOUBLE_EN
   localparam int FRAME_WORDS = (H_RES / 2) * (V_RES / 2);
`else
   localparam int FRAME_WORDS = H_RES * V_RES;
`endif
   localparam logic [ADDR_WIDTH-1:0] FRAME_WORDS_A = ADDR_WIDTH'(FRAME_WORDS);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic                  sof_s, eol_s, eof_s;
   logic [ADDR_WIDTH-1:0] base_s, addr_cur_s, addr_q, addr_d;
   swap_state_e           state_q, state_d;
   logic                  page_q, page_d, ack_q, ack_d;
   logic [3*D_WIDTH-1:0]  rgb_q;
   logic [2:0]            sync_lat_s, sync_out_s;

   assign sof_s = valid && (X == {P_WIDTH{1'b0}}) && (Y == {P_WIDTH{1'b0}});
   assign eol_s = valid && (X == P_WIDTH'(H_RES - 1));
   assign eof_s = eol_s && (Y == P_WIDTH'(V_RES - 1));

   // addr_q holds the address of the next visible pixel; (0,0) overrides it with the page base.
   assign base_s     = page_q ? FRAME_WORDS_A : {ADDR_WIDTH{1'b0}};
   assign addr_cur_s = sof_s ? base_s : addr_q;

`ifdef VGA_PIXEL_DOUBLE_EN
   logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;

   // Even lines replay from line_base; odd lines advance it to the next buffer row.
   always_comb begin
      addr_d      = addr_cur_s;
      line_base_d = sof_s ? base_s : line_base_q;
      if (!valid || eof_s) begin
         addr_d = addr_cur_s;
      end else if (eol_s) begin
         if (!Y[0]) begin
            addr_d = line_base_d;
         end else begin
            addr_d      = addr_cur_s + ADDR_ONE;
            line_base_d = addr_cur_s + ADDR_ONE;
         end
      end else if (X[0]) begin
         addr_d = addr_cur_s + ADDR_ONE;
      end else begin
         addr_d = addr_cur_s;
      end
   end

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) line_base_q <= {ADDR_WIDTH{1'b0}};
      else       line_base_q <= line_base_d;
   end
`else
   always_comb begin
      addr_d = addr_cur_s;
      if (valid && !eof_s) addr_d = addr_cur_s + ADDR_ONE;
      else                 addr_d = addr_cur_s;
   end
`endif

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) addr_q <= {ADDR_WIDTH{1'b0}};
      else       addr_q <= addr_d;
   end

   // One swap held at a time; it lands on the edge after EOF, ahead of the next (0,0).
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      ack_d   = 1'b0;
      case (state_q)
         SWAP_IDLE: begin
            if (swap_req) state_d = SWAP_PENDING;
            else          state_d = SWAP_IDLE;
         end
         SWAP_PENDING: begin
            if (eof_s) begin
               state_d = SWAP_IDLE;
               page_d  = ~page_q;
               ack_d   = 1'b1;
            end else begin
               state_d = SWAP_PENDING;
            end
         end
         default: state_d = SWAP_IDLE;
      endcase
   end

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= SWAP_IDLE;
         page_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         ack_q   <= ack_d;
      end
   end

   // First BRAM_LAT stages line up with read data; the last stage matches the colour register.
   vga_delay_line #(.WIDTH(3), .DEPTH(BRAM_LAT), .RST_VAL(3'b011)) u_dly_lat (
      .clk (VGA_CLK),
      .rst (RESET),
      .d_i ({valid, HS_in, VS_in}),
      .q_o (sync_lat_s)
   );

   vga_delay_line #(.WIDTH(3), .DEPTH(1), .RST_VAL(3'b011)) u_dly_out (
      .clk (VGA_CLK),
      .rst (RESET),
      .d_i (sync_lat_s),
      .q_o (sync_out_s)
   );

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET)              rgb_q <= {(3*D_WIDTH){1'b0}};
      else if (sync_lat_s[2]) rgb_q <= bram.bram_dout;
      else                    rgb_q <= {(3*D_WIDTH){1'b0}};
   end

   assign bram.bram_addr = addr_cur_s;
   assign bram.bram_en   = valid & ~RESET;
   assign swap_ack       = ack_q;
   assign page           = page_q;
   assign {Red, Green, Blue}          = rgb_q;
   assign {valid_out, HS_out, VS_out} = sync_out_s;
endmodule

// File: tb/tb_vga_bram_fetch.sv
// Randomised raster/swap stimulus against a frame-arithmetic reference model.
module tb_vga_bram_fetch;
   import vga_bram_fetch_pkg::*;

   localparam int H   = 16;
   localparam int V   = 8;
   localparam int HT  = H + 6;
   localparam int VT  = V + 3;
   localparam int AW  = 20;
   localparam int LAT = 1;
   localparam int DW3 = 3 * D_WIDTH;
`ifdef VGA_PIXEL_DOUBLE_EN
   localparam int FW = (H / 2) * (V / 2);
`else
   localparam int FW = H * V;
`endif

   typedef struct packed {
      logic           v;
      logic           hs;
      logic           vs;
      logic           known;
      logic [DW3-1:0] rgb;
   } rec_t;

   logic               clk = 1'b0;
   logic               rst;
   logic [P_WIDTH-1:0] x, y;
   logic               valid, hs, vs, swap_req;
   logic               swap_ack, page, valid_out, hs_out, vs_out;
   logic [D_WIDTH-1:0] red, green, blue;
   logic [DW3-1:0]     rd_pipe [LAT];

   vga_bram_fetch_if #(.ADDR_WIDTH(AW)) bram ();

   vga_bram_fetch #(.H_RES(H), .V_RES(V), .ADDR_WIDTH(AW), .BRAM_LAT(LAT)) dut (
      .VGA_CLK(clk), .RESET(rst), .X(x), .Y(y), .valid(valid),
      .HS_in(hs), .VS_in(vs), .bram(bram), .swap_req(swap_req),
      .swap_ack(swap_ack), .page(page), .Red(red), .Green(green), .Blue(blue),
      .valid_out(valid_out), .HS_out(hs_out), .VS_out(vs_out)
   );

   always #5 clk = ~clk;

   // Frame buffer whose word content equals its address; all-ones when not enabled.
   always @(posedge clk) begin
      rd_pipe[0] <= bram.bram_en ? DW3'(bram.bram_addr) : {DW3{1'b1}};
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bram.bram_dout = rd_pipe[LAT-1];

   int   n_tests = 0, n_fail = 0;
   int   hx, vy, frame, acks_dir;
   bit   synced, pend, page_m, rst_done, dir_checked;
   rec_t hist[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (frame %0d x %0d y %0d)", tag, got, exp, frame, hx, vy);
      end
   endtask

   function automatic int pix_off(input int px, input int py);
`ifdef VGA_PIXEL_DOUBLE_EN
      return (py / 2) * (H / 2) + px / 2;
`else
      return py * H + px;
`endif
   endfunction

   task automatic reset_model();
      rec_t r;
      page_m = 1'b0;
      pend   = 1'b0;
      synced = 1'b0;
      r = '{v: 1'b0, hs: 1'b1, vs: 1'b1, known: 1'b1, rgb: {DW3{1'b0}}};
      hist.delete();
      for (int i = 0; i < LAT; i++) hist.push_back(r);
   endtask

   task automatic check_reset_vals();
      check_val("rst_bram_addr", bram.bram_addr, 0);
      check_val("rst_bram_en", bram.bram_en, 0);
      check_val("rst_swap_ack", swap_ack, 0);
      check_val("rst_page", page, 0);
      check_val("rst_rgb", {red, green, blue}, 0);
      check_val("rst_valid_out", valid_out, 0);
      check_val("rst_hs_out", hs_out, 1);
      check_val("rst_vs_out", vs_out, 1);
   endtask

   task automatic drive_pixel(input bit req);
      x        = P_WIDTH'(hx);
      y        = P_WIDTH'(vy);
      valid    = (hx < H) && (vy < V);
      hs       = !(hx >= H + 1 && hx < H + 4);
      vs       = !(vy == V + 1);
      swap_req = req;
   endtask

   task automatic advance();
      hx++;
      if (hx == HT) begin
         hx = 0;
         vy++;
         if (vy == VT) begin
            vy = 0;
            frame++;
         end
      end
   endtask

   task automatic cycle(input bit req);
      rec_t r;
      bit   eof, exp_ack;
      int   ea;
      drive_pixel(req);
      if (valid && hx == 0 && vy == 0) synced = 1'b1;
      eof = valid && hx == H - 1 && vy == V - 1;
      ea  = (page_m ? FW : 0) + pix_off(hx, vy);
      #3;
      check_val("bram_en", bram.bram_en, valid);
      if (valid && synced) check_val("bram_addr", bram.bram_addr, ea);
      r.v     = valid;
      r.hs    = hs;
      r.vs    = vs;
      r.known = !valid || synced;
      r.rgb   = valid ? DW3'(ea) : {DW3{1'b0}};
      hist.push_back(r);
      @(posedge clk);
      #1;
      exp_ack = 1'b0;
      if (pend && eof) begin
         pend    = 1'b0;
         page_m  = ~page_m;
         exp_ack = 1'b1;
      end else if (!pend && req) begin
         pend = 1'b1;
      end
      check_val("swap_ack", swap_ack, exp_ack);
      check_val("page", page, page_m);
      if (frame < 6 && swap_ack) acks_dir++;
      r = hist.pop_front();
      check_val("valid_out", valid_out, r.v);
      check_val("hs_out", hs_out, r.hs);
      check_val("vs_out", vs_out, r.vs);
      if (r.known) check_val("rgb", {red, green, blue}, r.rgb);
      advance();
   endtask

   task automatic mid_reset();
      drive_pixel(1'b0);
      #3;
      rst = 1'b1;
      #1;
      check_reset_vals();
      repeat (3) begin
         @(posedge clk);
         #1;
         advance();
         drive_pixel(1'b0);
      end
      reset_model();
      rst = 1'b0;
   endtask

   initial begin
      bit req;
      rst = 1'b1;
      hx = 7;
      vy = 5;
      frame = 0;
      acks_dir = 0;
      rst_done = 1'b0;
      dir_checked = 1'b0;
      drive_pixel(1'b0);
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      rst = 1'b0;
      while (frame < 40) begin
         if (frame < 6)
            req = (frame == 1 && ((hx == 3 && vy == 2) || (hx == 7 && vy == 4))) ||
                  (frame == 3 && hx == H - 1 && vy == V - 1);
         else
            req = ($urandom_range(63) == 0);
         if (!rst_done && frame >= 20 && (page_m || frame >= 30) && hx == 5 && vy == 3) begin
            mid_reset();
            rst_done = 1'b1;
         end else begin
            cycle(req);
         end
         if (frame == 6 && !dir_checked) begin
            check_val("directed_ack_count", acks_dir, 2);
            dir_checked = 1'b1;
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
